// File: rtl/pipe_stage_if.sv
// Handshake and payload bundle between two adjacent pipeline stages.
// The slave side is the stage latch; the master side is the surrounding pipeline.
interface pipe_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_FIELDS = 7,
  parameter int unsigned CTRL_WIDTH = 64
);
  localparam int unsigned FW = NUM_FIELDS * DATA_WIDTH;

  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_fields;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_fields;
  logic [CTRL_WIDTH-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_fields, in_ctrl, out_ready,
    output in_ready, out_valid, out_fields, out_ctrl
  );

  modport master (
    output in_valid, in_fields, in_ctrl, out_ready,
    input  in_ready, out_valid, out_fields, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_latch.sv
// Pipeline stage latch with valid/ready handshake and a 2-entry skid buffer.
// in_ready comes only from registered state; also reports occupancy and a saturating stall count.
module pipe_stage_latch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_FIELDS = 7,
  parameter int unsigned CTRL_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_stage_if.slave          bus,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_count
);
  localparam int unsigned FW = NUM_FIELDS * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [FW-1:0]         main_fields_q, main_fields_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [FW-1:0]         skid_fields_q, skid_fields_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.in_valid && (state_q != FULL);
  assign out_xfer = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    state_d       = state_q;
    main_fields_d = main_fields_q;
    main_ctrl_d   = main_ctrl_q;
    skid_fields_d = skid_fields_q;
    skid_ctrl_d   = skid_ctrl_q;
    stall_d       = stall_q;

    // Stall counting is independent of flush; only reset clears it.
    if ((state_q != EMPTY) && !bus.out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end

    if (flush) begin
      state_d       = EMPTY;
      main_fields_d = '0;
      main_ctrl_d   = '0;
      skid_fields_d = '0;
      skid_ctrl_d   = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_fields_d = bus.in_fields;
            main_ctrl_d   = bus.in_ctrl;
            state_d       = ONE;
          end
        end
        ONE: begin
          if (out_xfer && in_xfer) begin
            main_fields_d = bus.in_fields;
            main_ctrl_d   = bus.in_ctrl;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer) begin
            skid_fields_d = bus.in_fields;
            skid_ctrl_d   = bus.in_ctrl;
            state_d       = FULL;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_fields_d = skid_fields_q;
            main_ctrl_d   = skid_ctrl_q;
            state_d       = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= EMPTY;
      main_fields_q <= '0;
      main_ctrl_q   <= '0;
      skid_fields_q <= '0;
      skid_ctrl_q   <= '0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      main_fields_q <= main_fields_d;
      main_ctrl_q   <= main_ctrl_d;
      skid_fields_q <= skid_fields_d;
      skid_ctrl_q   <= skid_ctrl_d;
      stall_q       <= stall_d;
    end
  end

  assign bus.in_ready   = (state_q != FULL);
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_fields = main_fields_q;
  assign bus.out_ctrl   = main_ctrl_q;
  assign occupancy      = 2'(state_q);
  assign stall_count    = stall_q;
endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch: reset, streaming, skid/backpressure,
// flush, stall-counter saturation and mid-stream reset.
module tb_pipe_stage_latch;
  localparam int unsigned DW = 8;
  localparam int unsigned NF = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned KW = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [1:0]    occupancy;
  logic [KW-1:0] stall_count;
  int checks   = 0;
  int failures = 0;

  pipe_stage_if #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .CTRL_WIDTH(CW)) bus ();

  pipe_stage_latch #(
    .DATA_WIDTH(DW), .NUM_FIELDS(NF), .CTRL_WIDTH(CW), .CNT_WIDTH(KW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus),
    .occupancy   (occupancy),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fld(input logic [7:0] v);
    return {v ^ 8'hFF, v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    bus.in_valid  = v;
    bus.in_fields = fld(d);
    bus.in_ctrl   = d;
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [1:0] occ,
                          input logic rdy, input logic [7:0] d);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
    chk({tag, "_occ"},   64'(occupancy),     64'(occ));
    chk({tag, "_ready"}, 64'(bus.in_ready),  64'(rdy));
    if (v) begin
      chk({tag, "_fields"}, 64'(bus.out_fields), 64'(fld(d)));
      chk({tag, "_ctrl"},   64'(bus.out_ctrl),   64'(d));
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 8'h00);
    step();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      step();
      chk_head("idle", 1'b0, 2'd0, 1'b1, 8'h00);
      chk("idle_fields", 64'(bus.out_fields), 64'd0);
      chk("idle_ctrl",   64'(bus.out_ctrl),   64'd0);
      chk("idle_stall",  64'(stall_count),    64'd0);
    end

    // Stream 1..8 at full rate
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i));
      step();
      chk_head("stream", 1'b1, 2'd1, 1'b1, 8'(i));
      chk("stream_stall", 64'(stall_count), 64'd0);
    end
    drive(1'b0, 8'h00);
    step();
    chk_head("drain", 1'b0, 2'd0, 1'b1, 8'h00);
    chk("drain_hold", 64'(bus.out_fields), 64'(fld(8'h08)));

    // Backpressure: A in main, B into skid, C held upstream
    drive(1'b1, 8'hA0);
    step();
    chk_head("a_head", 1'b1, 2'd1, 1'b1, 8'hA0);
    bus.out_ready = 1'b0;
    drive(1'b1, 8'hB0);
    step();
    chk_head("b_skid", 1'b1, 2'd2, 1'b0, 8'hA0);
    chk("b_stall", 64'(stall_count), 64'd1);
    drive(1'b1, 8'hC0);
    step();
    chk_head("c_held1", 1'b1, 2'd2, 1'b0, 8'hA0);
    chk("c_stall1", 64'(stall_count), 64'd2);
    step();
    chk("c_stall2", 64'(stall_count), 64'd3);
    bus.out_ready = 1'b1;
    step();
    chk_head("emit_b", 1'b1, 2'd1, 1'b1, 8'hB0);
    chk("emit_stall", 64'(stall_count), 64'd3);
    step();
    chk_head("emit_c", 1'b1, 2'd1, 1'b1, 8'hC0);
    drive(1'b0, 8'h00);
    step();
    chk_head("abc_empty", 1'b0, 2'd0, 1'b1, 8'h00);

    // Fill to two entries, then flush with D presented
    bus.out_ready = 1'b0;
    drive(1'b1, 8'hE1);
    step();
    drive(1'b1, 8'hE2);
    step();
    chk_head("pre_flush", 1'b1, 2'd2, 1'b0, 8'hE1);
    chk("pre_flush_stall", 64'(stall_count), 64'd4);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'hD0);
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00);
    chk_head("flush", 1'b0, 2'd0, 1'b1, 8'h00);
    chk("flush_fields", 64'(bus.out_fields), 64'd0);
    chk("flush_ctrl",   64'(bus.out_ctrl),   64'd0);
    chk("flush_stall",  64'(stall_count),    64'd4);
    step();
    chk_head("no_d", 1'b0, 2'd0, 1'b1, 8'h00);

    // Saturation: 21 blocked cycles from a count of 4
    bus.out_ready = 1'b0;
    drive(1'b1, 8'hF0);
    step();
    drive(1'b0, 8'h00);
    chk("sat_start", 64'(stall_count), 64'd4);
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k == 10) chk("sat_14", 64'(stall_count), 64'd14);
      if (k == 11) chk("sat_15", 64'(stall_count), 64'd15);
    end
    chk("sat_hold", 64'(stall_count), 64'd15);
    chk_head("sat_head", 1'b1, 2'd1, 1'b1, 8'hF0);

    // Reset with two entries held and an input pending
    drive(1'b1, 8'h61);
    step();
    chk_head("pre_reset", 1'b1, 2'd2, 1'b0, 8'hF0);
    reset = 1'b1;
    drive(1'b1, 8'h62);
    step();
    reset = 1'b0;
    drive(1'b0, 8'h00);
    chk_head("reset", 1'b0, 2'd0, 1'b1, 8'h00);
    chk("reset_fields", 64'(bus.out_fields), 64'd0);
    chk("reset_ctrl",   64'(bus.out_ctrl),   64'd0);
    chk("reset_stall",  64'(stall_count),    64'd0);
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h77);
    step();
    chk_head("post_reset", 1'b1, 2'd1, 1'b1, 8'h77);
    drive(1'b0, 8'h00);
    step();
    chk_head("post_drain", 1'b0, 2'd0, 1'b1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_latch.md
# pipe_stage_latch

Parametrised successor to the fixed decode/execute stage latch. It carries NUM_FIELDS data words plus one control word between pipeline stages. It adds a valid/ready handshake, a 2-entry skid buffer so the upstream ready has no combinational path from downstream, prioritised flush, occupancy reporting and a saturating stall counter. One instance sits between each pair of adjacent pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- DATA_WIDTH, default 32: width of each data field (rv32i_word).
- NUM_FIELDS, default 7: number of data fields carried (rs1, rs2, i/b/u/j/s immediates).
- CTRL_WIDTH, default 64: width of the flattened control word.
- CNT_WIDTH, default 16: width of the stall counter.

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: discard all held entries and any input transfer in the same cycle.
- in_valid, input, 1: upstream presents an entry.
- in_ready, output, 1: latch can accept an entry; driven only from registered state.
- in_fields, input, NUM_FIELDS*DATA_WIDTH: packed data fields; field k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_ctrl, input, CTRL_WIDTH: control word.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: downstream accepts the head entry this cycle.
- out_fields, output, NUM_FIELDS*DATA_WIDTH: head entry data.
- out_ctrl, output, CTRL_WIDTH: head entry control.
- occupancy, output, 2: number of held entries (0, 1 or 2).
- stall_count, output, CNT_WIDTH: count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage is a main register (head, drives the outputs) and a skid register. The state is EMPTY, ONE or FULL. occupancy encodes the state as 0, 1 or 2.
- in_ready = (state != FULL). An input transfer occurs when in_valid and in_ready are both 1. An output transfer occurs when out_valid and out_ready are both 1.
- State transitions, applied when flush=0 and reset=0:
  - EMPTY:
    - input transfer → main loaded, go to ONE.
    - otherwise → stay in EMPTY.
  - ONE:
    - output and input transfer → main reloaded, stay in ONE.
    - output transfer only → go to EMPTY.
    - input transfer only → skid loaded, go to FULL.
    - neither → hold.
  - FULL:
    - output transfer → main ← skid, go to ONE.
    - otherwise → hold.
    - in_valid is ignored in FULL.
- Priority is reset, then flush, then the handshake.
- Flush:
  - Next state is EMPTY.
  - Main and skid payloads are zeroed.
  - An input transfer in the flush cycle is dropped.
  - An output transfer in the flush cycle still counts as consumed for downstream; the latch does not replay it.
- Reset:
  - State goes to EMPTY, payloads to zero, stall_count to 0.
  - Reset mid-transfer drops the entry.
- Payload when draining to EMPTY without a refill: the main payload holds its last value. Consumers must qualify with out_valid. Only reset and flush guarantee zeros.
- stall_count:
  - Increments by 1 on each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_WIDTH−1.
  - Cleared by reset only; flush does not clear it.
- Ordering is strict FIFO. An entry never overtakes another, and no entry is duplicated.

## Timing
- Reset values: out_valid=0, in_ready=1, occupancy=0, stall_count=0, out_fields=0, out_ctrl=0.
- Latency: an entry accepted at edge N is on out_* with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 entry per cycle while out_ready=1 continuously.
- in_ready changes only on a clock edge. There is no combinational path from out_ready or in_valid to in_ready.
- The cycle after out_ready falls with an input transfer, the entry lands in skid and in_ready goes to 0. One extra entry is absorbed without loss.
- Outputs after a flush asserted at edge N: out_valid=0, occupancy=0 and in_ready=1 from cycle N+1.
- Simultaneous flush and reset behave as reset.

## Test plan
- Reset, then hold in_valid=0 for 3 cycles → out_valid=0, in_ready=1, occupancy=0, out_fields=0, stall_count=0 every cycle.
- Stream the entries 0x1..0x8 with out_ready=1 → each appears one cycle after acceptance, in order, one per cycle; occupancy stays ≤1 and stall_count stays 0.
- Send A, then drop out_ready while presenting B, C:
  - B goes into skid, occupancy=2, in_ready=0, and C is held upstream.
  - stall_count increments on every blocked cycle.
  - Raise out_ready: A, B, C emerge in order with no loss and no duplication.
- With occupancy=2, assert flush together with in_valid=1 (entry D):
  - Next cycle: out_valid=0, occupancy=0, out_fields=0, out_ctrl=0, in_ready=1.
  - D never appears.
  - stall_count is unchanged by the flush.
- Hold out_valid=1 and out_ready=0 for 2^CNT_WIDTH+5 cycles (CNT_WIDTH=4 in test) → stall_count reaches 15 and stays at 15.
- Assert reset mid-stream with occupancy=2 → next cycle all reset values hold; the following accepted entry emerges normally.
